// File: rtl/control_unit_pkg.sv
// Shared encodings for the microprogrammed control unit.
package control_unit_pkg;

    localparam int unsigned STATE_W_DEFAULT = 10;

    // Next-state (N) field of the control word.
    typedef enum logic [2:0] {
        N_DISPATCH = 3'd0,
        N_FETCH    = 3'd1,
        N_INC      = 3'd2,
        N_JUMP     = 3'd3,
        N_BRANCH   = 3'd4,
        N_WAIT     = 3'd5,
        N_CALL     = 3'd6,
        N_RETURN   = 3'd7
    } n_sel_e;

    // Test-signal select field of the control word.
    typedef enum logic [1:0] {
        SEL_MOC  = 2'd0,
        SEL_COND = 2'd1,
        SEL_DONE = 2'd2,
        SEL_TRUE = 2'd3
    } sel_e;

endpackage

// File: rtl/condition_select.sv
// Picks the test signal named by the control word and applies the invert bit.
module condition_select
    import control_unit_pkg::*;
(
    input  logic [1:0] select,
    input  logic       inv,
    input  logic       moc,
    input  logic       cond,
    input  logic       done,
    output logic       t
);

    logic t_raw;

    // 4:1 test mux followed by optional inversion.
    always_comb begin
        t_raw = 1'b0;
        unique case (select)
            SEL_MOC:  t_raw = moc;
            SEL_COND: t_raw = cond;
            SEL_DONE: t_raw = done;
            SEL_TRUE: t_raw = 1'b1;
            default:  t_raw = 1'b0;
        endcase
        t = t_raw ^ inv;
    end

endmodule

// File: rtl/microsequencer.sv
// Next-address sequencer: dispatch/fetch/increment/jump/branch/wait/call/return,
// with a bounded wait loop that aborts to ABORT_STATE.
module microsequencer
    import control_unit_pkg::*;
#(
    parameter int unsigned         STATE_W     = STATE_W_DEFAULT,
    parameter logic [STATE_W-1:0]  RESET_STATE = '0,
    parameter logic [STATE_W-1:0]  FETCH_STATE = STATE_W'(1),
    parameter logic [STATE_W-1:0]  ABORT_STATE = STATE_W'(2),
    parameter int unsigned         WAIT_LIMIT  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         n_sel,
    input  logic               inv,
    input  logic [1:0]         select,
    input  logic [STATE_W-1:0] cr,
    input  logic [STATE_W-1:0] dispatch_state,
    input  logic               moc,
    input  logic               cond,
    input  logic               done,
    output logic [STATE_W-1:0] current_state,
    output logic [STATE_W-1:0] ret_state,
    output logic               timeout
);

    logic               t;
    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] ret_q, ret_d;
    logic [7:0]         count_q, count_d;
    logic               timeout_q, timeout_d;
    logic [STATE_W-1:0] state_inc;
    logic               wait_fail;
    logic               abort;

    condition_select u_condition_select (
        .select (select),
        .inv    (inv),
        .moc    (moc),
        .cond   (cond),
        .done   (done),
        .t      (t)
    );

    assign state_inc = state_q + STATE_W'(1);  // wraps modulo 2^STATE_W
    assign wait_fail = (n_sel == N_WAIT) && !t;
    // A passing test on the last allowed cycle wins over the abort.
    assign abort     = wait_fail && (count_q == 8'(WAIT_LIMIT - 1));

    // Next address, return register, wait counter and timeout pulse.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        count_d   = 8'd0;
        timeout_d = 1'b0;
        unique case (n_sel)
            N_DISPATCH: state_d = dispatch_state;
            N_FETCH:    state_d = FETCH_STATE;
            N_INC:      state_d = state_inc;
            N_JUMP:     state_d = cr;
            N_BRANCH:   state_d = t ? cr : state_inc;
            N_WAIT:     state_d = t ? cr : state_q;
            N_CALL: begin
                ret_d   = state_inc;
                state_d = cr;
            end
            N_RETURN:   state_d = ret_q;
            default:    state_d = state_q;
        endcase
        if (abort) begin
            state_d   = ABORT_STATE;
            timeout_d = 1'b1;
        end else if (wait_fail) begin
            count_d = count_q + 8'd1;
        end
    end

    // Sequencer state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            ret_q     <= RESET_STATE;
            count_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign current_state = state_q;
    assign ret_state     = ret_q;
    assign timeout       = timeout_q;

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state sequencer for the microprogrammed control unit. Each cycle it reads the next-state fields of the latched control word (N, inv, select, cr) and picks the next microstore address from: the instruction-dispatch address, a fixed fetch state, the incremented state, the cr target, or a single-level return register. It also runs a bounded wait loop for memory and condition handshakes. Its registered `current_state` output addresses the microstore ROM, and the ROM output is latched by the control register.

## Interface
- `STATE_W`, 10: microstore address width.
- `RESET_STATE`, 10'd0: state after reset.
- `FETCH_STATE`, 10'd1: target of N=FETCH.
- `ABORT_STATE`, 10'd2: target when a wait loop times out.
- `WAIT_LIMIT`, 15: maximum consecutive failed wait cycles before abort (range 1..255).

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `n_sel`  in  3  N field of control word.
- `inv`  in  1  inverts the selected test signal.
- `select`  in  2  test-signal select: 0=moc, 1=cond, 2=done, 3=constant 1.
- `cr`  in  STATE_W  branch/call target from control word.
- `dispatch_state`  in  STATE_W  start state from instruction encoder.
- `moc`  in  1  memory operation complete.
- `cond`  in  1  condition-code evaluation result.
- `done`  in  1  multi-cycle datapath operation finished.
- `current_state`  out  STATE_W  registered microstore address.
- `ret_state`  out  STATE_W  return register contents (debug/verification).
- `timeout`  out  1  one-cycle registered pulse on wait abort.

## Operation
- Test: `t = mux(select){moc, cond, done, 1} ^ inv`.
- N encodings:
  - 0 DISPATCH: next = dispatch_state.
  - 1 FETCH: next = FETCH_STATE.
  - 2 INC: next = current_state+1.
  - 3 JUMP: next = cr.
  - 4 BRANCH: next = t ? cr : current_state+1.
  - 5 WAIT: next = t ? cr : current_state (hold).
  - 6 CALL: ret_state <= current_state+1; next = cr.
  - 7 RETURN: next = ret_state.
- Increment is modulo 2^STATE_W; 1023+1 wraps to 0 at the default width.
- Return register has one level. A nested CALL overwrites it. RETURN without a prior CALL goes to its reset value (RESET_STATE).
- Wait counter (8 bit):
  - Increments on each N=5 cycle with t=0.
  - Clears on any cycle with N≠5 or t=1.
  - If N=5, t=0 and count==WAIT_LIMIT-1: next = ABORT_STATE, timeout asserts at the next edge for one cycle, and the counter clears.
  - t=1 on that same cycle takes priority: branch to cr, no timeout.
- Out-of-range N is impossible (3-bit field fully decoded).

## Timing
- Reset values (asynchronous): current_state=RESET_STATE, ret_state=RESET_STATE, count=0, timeout=0.
- The first rising edge after rst_n deasserts evaluates the control word normally.
- Inputs are sampled at rising edge k. current_state is valid after edge k, so one-cycle latency from control word to address.
- The control register latches ROM[current_state] on the same edge. A branch decision therefore takes effect on the word two edges later, as the control unit expects.
- WAIT holds current_state, so the control word repeats every cycle.
- Full timeout path: exactly WAIT_LIMIT failed cycles, then ABORT_STATE.
- `moc`, `cond`, `done` must be synchronous to clk. No internal synchronizers.
- Reset mid-wait or mid-call clears count and ret_state immediately. A timeout pulse in flight is dropped.

## Structure
- Package `control_unit_pkg`:
  - N encodings: N_DISPATCH..N_RETURN.
  - Select encodings: SEL_MOC, SEL_COND, SEL_DONE, SEL_TRUE.
  - STATE_W default.
- Sub-module `condition_select`: combinational 4:1 test mux plus inv XOR.
- All sequential logic (state, return register, wait counter, timeout) lives in `microsequencer`.

## Test plan
- Reset: rst_n low mid-cycle with state=37 → current_state=0 and timeout=0 immediately (asynchronous). Release, N=2 → 1.
- Sequential paths:
  - N=2 at state 1023 → 0.
  - N=3, cr=300 → 300.
  - N=0, dispatch_state=150 → 150.
  - N=1 → 1.
- Branch: N=4, select=1, cond=1, inv=0, cr=200, state=10 → 200. Same with inv=1 → 11.
- Wait: N=5, select=0, cr=40, state=20, moc low 3 cycles then high → state stays 20 for 3 cycles then 40, with no timeout. moc high on cycle 14 (count=14) → 40, not abort.
- Timeout: WAIT_LIMIT=15, moc held low → 14 holds at 20, then current_state=2 with timeout high exactly one cycle. Counter clear verified by a second wait taking 15 cycles again.
- Call/return:
  - N=6 at state 50, cr=500 → 500, ret_state=51. Then N=7 → 51.
  - Nested CALL at 500 → ret_state=501.
  - RETURN immediately after reset → 0.
